// File: rtl/apb_pkg.sv
// Shared APB types and constants: width limits, completer FSM states, PPROT bit positions.
package apb_pkg;

    localparam int APB_MAX_ADDR_WIDTH = 32;
    localparam int APB_MAX_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int PPROT_PRIV_BIT   = 0;
    localparam int PPROT_NSEC_BIT   = 1;
    localparam int PPROT_INSTR_BIT  = 2;

    // Number of low address bits that select a byte within one data word.
    function automatic int lane_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB bus bundle shared by one master and NUM_SLAVES completers (one psel bit each).
interface apb_interface #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 2
) (
    input logic pclk,
    input logic prstn
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [2:0]            pprot;
    logic                  pnse;
    logic [NUM_SLAVES-1:0] psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        input  pclk, prstn,
        output paddr, pprot, pnse, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    // Completers only listen; their responses are muxed by psel at the top level.
    modport slave (
        input paddr, pprot, pnse, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/apb_defines.sv
// Global APB width limits as preprocessor macros for code that cannot import apb_pkg.
`ifndef APB_DEFINES_SV
`define APB_DEFINES_SV
`define APB_MAX_ADDR_WIDTH 32
`define APB_MAX_DATA_WIDTH 32
`endif

// File: rtl/apb_slave_regfile.sv
// Word register array with asynchronous clear, one write port and a combinational read port.
module apb_slave_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] words [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] word_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (we && (idx == IDX_W'(gi))) begin
                    word_reg <= wdata;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    assign rdata = words[idx];

endmodule

// File: rtl/apb_slave.sv
// APB completer exposing DEPTH word registers with PSLVERR on misaligned/out-of-range access.
// Optional wait states are enabled by defining APB_SLAVE_WAIT_EN.
module apb_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_MAX_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_MAX_DATA_WIDTH,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int SLAVE_IDX   = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    apb_interface.slave           bus,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);
    localparam int S     = lane_shift(DATA_WIDTH);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((1 << S) - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IDX_W-1:0]      idx;
    logic                  addr_err;
    logic                  access;
    logic                  ready;
    logic                  we;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_ok;

    apb_state_e state_reg, state_next;

    assign psel    = bus.psel[SLAVE_IDX];
    assign penable = bus.penable;
    assign pwrite  = bus.pwrite;
    assign access  = psel && penable;

    // Upper address bits take part in the range check, so aliases above DEPTH error out.
    assign word_addr = bus.paddr >> S;
    assign idx       = word_addr[IDX_W-1:0];
    assign addr_err  = ((bus.paddr & LANE_MASK) != '0) || (word_addr >= DEPTH_A);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                // An enable without a preceding setup phase is taken as an access.
                if (psel) begin
                    state_next = penable ? ACCESS : SETUP;
                end
            end
            SETUP: begin
                if (!psel) begin
                    state_next = IDLE;
                end else if (penable) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_next = IDLE;
                end else if (!penable) begin
                    state_next = SETUP;
                end else if (ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef APB_SLAVE_WAIT_EN
    logic [3:0] cnt_reg, cnt_next;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // The first enabled cycle is spent reaching ACCESS, hence the load of WAIT_CYCLES-1.
    always_comb begin
        cnt_next = cnt_reg;
        if ((state_next == ACCESS) && (state_reg != ACCESS)) begin
            cnt_next = 4'(WAIT_CYCLES - 1);
        end else if ((state_reg == ACCESS) && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - 4'd1;
        end
    end

    assign ready     = access && (state_reg == ACCESS) && (cnt_reg == '0);
    assign unused_ok = ^{bus.pprot, bus.pnse};
`else
    assign ready     = access;
    assign unused_ok = ^{bus.pprot, bus.pnse, 32'(WAIT_CYCLES)};
`endif

    assign we = ready && pwrite && !addr_err;

    apb_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_regfile (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .we    (we),
        .idx   (idx),
        .wdata (bus.pwdata),
        .rdata (rd_word)
    );

    assign PREADY  = ready;
    assign PSLVERR = ready && addr_err;
    assign PRDATA  = (ready && !pwrite && !addr_err) ? rd_word : '0;

endmodule

// File: tb/tb_apb_slave.sv
// Two-completer APB bench: randomized transfers scored against a word-array reference model.
module tb_apb_slave;
    import apb_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int WAIT  = 2;
`ifdef APB_SLAVE_WAIT_EN
    localparam int XFER_LEN = 2 + WAIT;
`else
    localparam int XFER_LEN = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(2)) bus (
        .pclk  (clk),
        .prstn (rst_n)
    );

    logic [1:0]    s_pready;
    logic [1:0]    s_pslverr;
    logic [DW-1:0] s_prdata [2];

    apb_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT), .SLAVE_IDX(0)) u_s0 (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus.slave),
        .PREADY  (s_pready[0]),
        .PRDATA  (s_prdata[0]),
        .PSLVERR (s_pslverr[0])
    );

    apb_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT), .SLAVE_IDX(1)) u_s1 (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus.slave),
        .PREADY  (s_pready[1]),
        .PRDATA  (s_prdata[1]),
        .PSLVERR (s_pslverr[1])
    );

    assign bus.pready  = bus.psel[0] ? s_pready[0]  : bus.psel[1] ? s_pready[1]  : 1'b0;
    assign bus.pslverr = bus.psel[0] ? s_pslverr[0] : bus.psel[1] ? s_pslverr[1] : 1'b0;
    assign bus.prdata  = bus.psel[0] ? s_prdata[0]  : bus.psel[1] ? s_prdata[1]  : '0;

    typedef struct {
        int            slv;
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        bit            err;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] model [2][DEPTH];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            len;
    bit            drv_done = 0;
    bit            final_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit ref_err(input logic [AW-1:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic idle(input int n);
        bus.psel    = '0;
        bus.penable = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is positioned just after a rising edge; returns just after the completing edge.
    task automatic xfer(input int slv, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        int   n;
        e.slv   = slv;
        e.write = wr;
        e.addr  = addr;
        e.err   = ref_err(addr);
        e.rdata = '0;
        if (!e.err) begin
            if (wr) model[slv][addr / 4] = data;
            else    e.rdata = model[slv][addr / 4];
        end
        exp_q.push_back(e);
        bus.psel         = '0;
        bus.psel[slv]    = 1'b1;
        bus.penable      = 1'b0;
        bus.pwrite       = wr;
        bus.paddr        = addr;
        bus.pwdata       = data;
        bus.pprot        = '0;
        bus.pprot[PPROT_PRIV_BIT]  = 1'($urandom_range(0, 1));
        bus.pprot[PPROT_NSEC_BIT]  = 1'($urandom_range(0, 1));
        bus.pprot[PPROT_INSTR_BIT] = 1'($urandom_range(0, 1));
        bus.pnse         = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1 bus.penable = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.pready) break;
            n++;
            if (n > 40) begin
                $display("FAIL pready_timeout slv=%0d addr=%h got no pready within 40 cycles, required one", slv, addr);
                $fatal(1, "transfer timeout");
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!bus.psel[i]) begin
                checks++;
                if (s_pready[i] !== 1'b0 || s_pslverr[i] !== 1'b0 || s_prdata[i] !== '0) begin
                    errors++;
                    $display("FAIL idle_outputs slv=%0d got pready=%b pslverr=%b prdata=%h, required 0/0/0",
                             i, s_pready[i], s_pslverr[i], s_prdata[i]);
                end
            end
        end
        if (rst_n) begin
            if ((|bus.psel) && !bus.penable) start_cyc = cyc;
            if (bus.pready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pready got pready=1 with no transfer outstanding, required 0");
                end else begin
                    mon_e = exp_q.pop_front();
                    len = cyc - start_cyc + 1;
                    if (bus.prdata !== mon_e.rdata) begin
                        errors++;
                        $display("FAIL prdata slv=%0d addr=%h got %h required %h", mon_e.slv, mon_e.addr, bus.prdata, mon_e.rdata);
                    end
                    checks++;
                    if (bus.pslverr !== mon_e.err) begin
                        errors++;
                        $display("FAIL pslverr slv=%0d addr=%h got %b required %b", mon_e.slv, mon_e.addr, bus.pslverr, mon_e.err);
                    end
                    checks++;
                    if (len != XFER_LEN) begin
                        errors++;
                        $display("FAIL xfer_length slv=%0d addr=%h got %0d cycles required %0d", mon_e.slv, mon_e.addr, len, XFER_LEN);
                    end
                    $display("xfer slv=%0d %s addr=%h prdata=%h pslverr=%b cycles=%0d",
                             mon_e.slv, mon_e.write ? "WR" : "RD", mon_e.addr, bus.prdata, bus.pslverr, len);
                end
            end else if (|bus.psel) begin
                checks++;
                if (bus.prdata !== '0 || bus.pslverr !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_outputs got prdata=%h pslverr=%b before pready, required 0/0", bus.prdata, bus.pslverr);
                end
            end
        end
        if (drv_done && !final_done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL outstanding got %0d unanswered transfers, required 0", exp_q.size());
            end
            final_done = 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no end of test by 400us, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] addr;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++)
                model[s][i] = '0;
        bus.psel = '0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0; bus.pprot = '0; bus.pnse = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        xfer(0, 0, 32'h4, '0);
        xfer(0, 1, 32'h8, 32'hDEADBEEF);
        xfer(0, 0, 32'h8, '0);
        xfer(0, 1, 32'h40, 32'h12345678);
        xfer(0, 0, 32'h0, '0);
        xfer(0, 0, 32'h40, '0);
        xfer(0, 0, 32'h6, '0);
        xfer(0, 1, 32'h0, 32'hA5);
        xfer(1, 1, 32'h0, 32'h5A);
        xfer(0, 0, 32'h0, '0);
        xfer(1, 0, 32'h0, '0);
        idle(2);
        xfer(1, 1, 32'h3C, 32'hCAFEF00D);
        xfer(1, 0, 32'h3C, '0);
        xfer(1, 0, 32'h8000_003C, '0);
        xfer(0, 1, 32'h0000_0108, 32'hFFFF_FFFF);
        xfer(0, 0, 32'h8, '0);

        for (int t = 0; t < 120; t++) begin
            case ($urandom_range(0, 7))
                5:       addr = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
                6:       addr = 32'd64 + 32'($urandom_range(0, 63));
                7:       addr = (32'($urandom_range(1, 255)) << 24) | (32'($urandom_range(0, 15)) << 2);
                default: addr = 32'($urandom_range(0, 15)) << 2;
            endcase
            xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), addr, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Reset during the access phase of a write: the write must not land.
        xfer(0, 1, 32'h10, 32'h1111_2222);
        bus.psel    = 2'b01;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 32'h10;
        bus.pwdata  = 32'h5555_AAAA;
        @(posedge clk);
        #1 bus.penable = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        bus.psel    = '0;
        bus.penable = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++)
                model[s][i] = '0;
        @(posedge clk);
        #1;
        xfer(0, 0, 32'h10, '0);
        xfer(0, 0, 32'h8, '0);
        xfer(1, 0, 32'h3C, '0);

        idle(2);
        drv_done = 1;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave.md
# apb_slave

Parameterised APB (AMBA APB4/APB5 signal set) completer that exposes a small word-addressed register file with error signalling. Two or more instances sit behind the system APB bus and share PADDR, PENABLE, PWRITE and PWDATA. Each instance has its own PSEL bit, and the top level multiplexes PREADY, PRDATA and PSLVERR by PSEL. The bus bundle `apb_interface` carries the shared signals from the master to the slaves.

## Interface

Parameters:
- ADDR_WIDTH, 32 (`APB_MAX_ADDR_WIDTH`): PADDR width.
- DATA_WIDTH, 32 (`APB_MAX_DATA_WIDTH`): PWDATA/PRDATA width. Legal values are 8, 16 and 32.
- DEPTH, 16: number of registers. Must be a power of two, ≥2.
- WAIT_CYCLES, 2: wait states per access. Used only with `APB_SLAVE_WAIT_EN`. Range is 1..15.

Ports:
- PCLK  in  1  bus clock. All logic is rising-edge.
- PRESETn  in  1  reset. Asynchronous assert, active-low.
- PADDR  in  ADDR_WIDTH  byte address.
- PPROT  in  3  protection attributes. Accepted and ignored.
- PNSE  in  1  RME extension. Accepted and ignored.
- PSEL  in  1  select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PREADY  out  1  transfer complete.
- PRDATA  out  DATA_WIDTH  read data.
- PSLVERR  out  1  transfer error.

## Operation

- Byte lane shift: S = log2(DATA_WIDTH/8).
- Register index: IDX = PADDR >> S.
- Error condition: ERR = (PADDR[S-1:0] != 0) || (IDX >= DEPTH).
- State machine:
  - States are IDLE, SETUP and ACCESS.
  - IDLE→SETUP when PSEL && !PENABLE.
  - SETUP→ACCESS when PSEL && PENABLE.
  - ACCESS→IDLE when PREADY is high, or when PSEL drops.
  - PSEL && PENABLE in IDLE (a missing setup phase) is treated as ACCESS.
- Write: when PSEL && PENABLE && PREADY && PWRITE && !ERR, reg[IDX] ← PWDATA on that rising edge.
- Read: during PSEL && PENABLE && !PWRITE, PRDATA = ERR ? 0 : reg[IDX]. PRDATA is 0 at all other times.
- PSLVERR = PSEL && PENABLE && PREADY && ERR. It is 0 otherwise.
- An errored write leaves every register unchanged.
- PREADY is 0 whenever PSEL = 0.
- PADDR bits above the index field are not ignored. Any address at or beyond DEPTH×bytes-per-word gives ERR.

## Timing

- Reset values: PREADY = 0, PRDATA = 0, PSLVERR = 0, FSM in IDLE, all registers 0.
- Reset asserted mid-transfer aborts the transfer immediately. No write commits.
- Default build has zero wait states. PREADY = PSEL && PENABLE combinationally, so each transfer takes exactly 2 cycles (setup and access).
- Read data and PSLVERR are valid in the same cycle as PREADY.
- Back-to-back transfers (a new setup immediately after completion) are fully supported. There is no required idle cycle.
- A read immediately after a write to the same register returns the new value.

## Configuration

- `APB_SLAVE_WAIT_EN` defined:
  - A counter loads on entry to ACCESS.
  - PREADY stays 0 for WAIT_CYCLES access cycles and then asserts for one cycle.
  - Total transfer length is 2 + WAIT_CYCLES cycles.
  - PRDATA and PSLVERR are qualified by PREADY, and are 0 during wait states.
  - If PSEL drops during wait states, the counter is abandoned and the FSM returns to IDLE.
- `APB_SLAVE_WAIT_EN` undefined:
  - Counter logic is absent and WAIT_CYCLES has no effect.

## Structure

- Shared package `apb_pkg`:
  - `APB_MAX_ADDR_WIDTH` = 32 and `APB_MAX_DATA_WIDTH` = 32, also available via `apb_defines.sv`.
  - State enum `apb_state_e` {IDLE, SETUP, ACCESS}.
  - PPROT field constants.
- `apb_interface` bundles the bus signals: pclk, prstn, paddr, psel[1:0], penable, pwrite, pwdata, pready, prdata, pslverr.
- Sub-module `apb_slave_regfile` holds the register array with async-reset clear, a write port (we, idx, wdata) and a combinational read port. The top level keeps the FSM, decode and wait logic.

## Test plan

- Reset → PREADY = 0, PRDATA = 0 and PSLVERR = 0. A read of 0x4 after reset returns 0x00000000.
- Write 0xDEADBEEF to 0x8, then read 0x8 → 0xDEADBEEF. PSLVERR = 0, and each transfer takes 2 cycles.
- Write to 0x40 (DEPTH = 16) → PSLVERR = 1 with PREADY. A subsequent read of 0x0 is unchanged, and a read of 0x40 returns 0 with PSLVERR = 1.
- Read at 0x6 (misaligned) → PSLVERR = 1 and PRDATA = 0.
- With two slaves on psel[0] and psel[1], write 0xA5 to 0x0 on s0 and 0x5A to 0x0 on s1 → reads return 0xA5 and 0x5A respectively.
- With `APB_SLAVE_WAIT_EN` and WAIT_CYCLES = 2 → PREADY rises on the 4th cycle of each transfer. Deasserting PRESETn during a write wait state leaves the register at 0.
